cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Parametrised run controller that sits between the board or bench clock/reset and the CPU top.
- Stretches RESET into a multi-cycle core reset.
- Gates core execution with a clock enable in free-run, single-step or run-N modes.
- Counts executed cycles and flags halt or watchdog timeout.
- Replaces fixed clock/reset sequencing for all later labs.

Parameters:
CNT_W, 32, width of cycle counter and run_count
RST_CYCLES, 4, cycles core_rst stays high after RESET deasserts (>=1)
WDOG_LIMIT, 100000, executed cycles before timeout; 0 disables watchdog
PC_W, 32, width of pc_in (used only with breakpoint feature)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous active-high reset
mode  in  2  0=free-run, 1=single-step, 2=run-N, 3=reserved (treated as 0)
start  in  1  pulse: leave IDLE and begin execution in selected mode
step  in  1  pulse: one executed cycle in single-step mode
run_count  in  CNT_W  cycles to execute in run-N mode, sampled on start
halt_in  in  1  core signals halt (e.g. end-of-program)
pc_in  in  PC_W  core PC (breakpoint feature only)
core_rst  out  1  reset to CPU top
core_en  out  1  clock enable to CPU top; core advances on cycles with core_en=1
cycle_cnt  out  CNT_W  number of cycles with core_en=1 since last core reset
busy  out  1  high in RUN/STEP states
done  out  1  high in HALTED
timeout  out  1  high in TIMEOUT

Behaviour:
- Single clock CLK. Synchronous active-high RESET, sampled only on rising edge of CLK.
- Reset values: state=RST_HOLD, core_rst=1, core_en=0, cycle_cnt=0, busy=0, done=0, timeout=0, hold counter=0, remaining=0.
- All outputs are registered.
- FSM states: RST_HOLD, IDLE, RUN, STEP_WAIT, HALTED, TIMEOUT.
- RST_HOLD:
  - core_rst=1.
  - Hold counter increments each cycle.
  - When it reaches RST_CYCLES-1, go to IDLE next cycle with core_rst=0.
  - Exactly RST_CYCLES cycles with core_rst=1 after RESET falls.
- IDLE:
  - core_en=0.
  - On start: mode 0/3 goes to RUN; mode 1 goes to STEP_WAIT; mode 2 latches remaining=run_count and goes to RUN.
  - If mode 2 and run_count=0: go directly to HALTED, no cycle executed.
- RUN:
  - core_en=1 every cycle; cycle_cnt increments by 1 per core_en cycle.
  - In mode 2, remaining decrements each cycle; when remaining reaches 1 in a cycle, that is the last core_en cycle, then go to HALTED.
  - core_en deasserts the cycle after the Nth enabled cycle. N enabled cycles exactly.
- STEP_WAIT:
  - core_en=0 except for exactly one cycle following each step pulse.
  - A step pulse during that enable cycle is ignored.
  - step outside STEP_WAIT is ignored.
- Exit priority:
  - halt_in=1 in RUN or STEP_WAIT goes to HALTED, core_en=0 from next cycle.
  - halt_in is evaluated before run-N completion. Both together give HALTED, done=1 either way.
  - Watchdog: if WDOG_LIMIT!=0 and cycle_cnt reaches WDOG_LIMIT, go to TIMEOUT.
  - halt_in takes priority over watchdog in the same cycle.
- HALTED/TIMEOUT:
  - Sticky; core_en=0, cycle_cnt frozen.
  - start is ignored; only RESET leaves them.
- cycle_cnt wraps modulo 2^CNT_W with no flag.
- RESET mid-run: next cycle core_en=0, core_rst=1, all counters cleared, RST_HOLD restarts.
- start while busy: ignored.

Optional Feature:
Macro RUN_CTRL_BKPT_EN.
- Defined:
  - Adds inputs bkpt_addr [PC_W] and bkpt_valid [1], and output bkpt_hit [1] (reset 0).
  - In RUN/STEP_WAIT, when core_en=1 and bkpt_valid and pc_in==bkpt_addr, the FSM goes to IDLE next cycle (not HALTED).
  - bkpt_hit=1 until the next start.
  - cycle_cnt is preserved, so start resumes.
  - Priority: halt_in > breakpoint > watchdog > run-N completion.
- Undefined: ports absent; pc_in ignored.

Decomposition:
- Shared package: state encoding constants (3-bit) and mode encodings MODE_FREE=0, MODE_STEP=1, MODE_RUNN=2.
- One sub-module: run_cycle_counter (CNT_W counter with clear, enable, and compare-equal output). Instantiated for cycle_cnt and for the remaining down-count.

Test Plan:
- RESET high 3 cycles then low, RST_CYCLES=4 -> core_rst high exactly 4 cycles after RESET falls; state IDLE, all other outputs 0.
- mode=2, run_count=10, start -> core_en high exactly 10 consecutive cycles, cycle_cnt=10, done=1. Then run_count=0 after re-reset -> done=1, cycle_cnt=0.
- mode=1, three step pulses spaced 5 cycles apart, plus one step during an enable cycle -> exactly 3 core_en pulses, cycle_cnt=3.
- mode=0, halt_in asserted on enabled cycle 7 -> done=1, cycle_cnt=7, core_en=0 next cycle. Later start pulse -> no change.
- WDOG_LIMIT=50, mode=0, halt_in never -> timeout=1 with cycle_cnt=50. Variant with halt_in on cycle 50 -> done=1, timeout=0.
- RESET asserted mid-RUN at cycle_cnt=20 -> next cycle core_en=0, core_rst=1, cycle_cnt=0. With RUN_CTRL_BKPT_EN and bkpt_addr=0x0000_0010 matching -> IDLE, bkpt_hit=1; start resumes counting.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding and run modes.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4,
        ST_TIMEOUT   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_RUNN = 2'd2;

    // The reserved mode code behaves exactly like free-run.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_STEP || m == MODE_RUNN) ? m : MODE_FREE;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_counter.sv
// Generic up/down counter with synchronous clear, load, enable and an equality flag.
module run_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         down,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] count,
    output logic         eq
);

    // Clear wins over load, load wins over counting; wraps silently.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= down ? (count - W'(1)) : (count + W'(1));
        end
    end

    assign eq = (count == cmp_val);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller between board clock/reset and the CPU top: reset stretching,
// free-run / single-step / run-N gating, cycle counting, halt and watchdog.
// Optional breakpoint support is compiled in with RUN_CTRL_BKPT_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int WDOG_LIMIT = 100000,
    parameter int PC_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             step,
    input  logic [CNT_W-1:0] run_count,
    input  logic             halt_in,
    input  logic [PC_W-1:0]  pc_in,
`ifdef RUN_CTRL_BKPT_EN
    input  logic [PC_W-1:0]  bkpt_addr,
    input  logic             bkpt_valid,
    output logic             bkpt_hit,
`endif
    output logic             core_rst,
    output logic             core_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam bit               WDOG_ON   = (WDOG_LIMIT != 0);
    // Compare against LIMIT-1 so the trip happens on the LIMIT-th enabled cycle.
    localparam logic [CNT_W-1:0] WDOG_CMP  = WDOG_ON ? CNT_W'(WDOG_LIMIT - 1) : '0;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        run_mode;
    logic [1:0]        sel_mode;
    logic [CNT_W-1:0]  remaining;
    logic              wdog_eq;
    logic              remaining_zero;
    logic              load_remaining;
    logic              dec_remaining;
    logic              wdog_trip;
    logic              runn_done;
    logic              bkpt_match;

    assign sel_mode       = norm_mode(mode);
    assign load_remaining = (state == ST_IDLE) && start && (sel_mode == MODE_RUNN);
    assign dec_remaining  = core_en && (state == ST_RUN) && (run_mode == MODE_RUNN);
    assign wdog_trip      = WDOG_ON && core_en && wdog_eq;
    // A zero remainder can only appear through corruption; stop instead of wrapping.
    assign runn_done      = dec_remaining && ((remaining == CNT_W'(1)) || remaining_zero);

`ifdef RUN_CTRL_BKPT_EN
    assign bkpt_match = core_en && bkpt_valid && (pc_in == bkpt_addr);
`else
    logic unused_pc;
    assign unused_pc  = ^pc_in;
    assign bkpt_match = 1'b0;
`endif

    run_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk      (CLK),
        .clear    (RESET),
        .load     (1'b0),
        .load_val ('0),
        .en       (core_en),
        .down     (1'b0),
        .cmp_val  (WDOG_CMP),
        .count    (cycle_cnt),
        .eq       (wdog_eq)
    );

    run_cycle_counter #(.W(CNT_W)) u_remaining (
        .clk      (CLK),
        .clear    (RESET),
        .load     (load_remaining),
        .load_val (run_count),
        .en       (dec_remaining),
        .down     (1'b1),
        .cmp_val  ('0),
        .count    (remaining),
        .eq       (remaining_zero)
    );

    // Exit priority in RUN/STEP_WAIT: halt, breakpoint, watchdog, run-N completion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_RST_HOLD;
            hold_cnt <= '0;
            run_mode <= MODE_FREE;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
`ifdef RUN_CTRL_BKPT_EN
            bkpt_hit <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_RST_HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_IDLE;
                        core_rst <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        run_mode <= sel_mode;
`ifdef RUN_CTRL_BKPT_EN
                        bkpt_hit <= 1'b0;
`endif
                        if (sel_mode == MODE_STEP) begin
                            state <= ST_STEP_WAIT;
                            busy  <= 1'b1;
                        end else if (sel_mode == MODE_RUNN && run_count == '0) begin
                            state <= ST_HALTED;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                            core_en <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_STEP_WAIT: begin
                    if (halt_in) begin
                        state   <= ST_HALTED;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (bkpt_match) begin
                        state   <= ST_IDLE;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
`ifdef RUN_CTRL_BKPT_EN
                        bkpt_hit <= 1'b1;
`endif
                    end else if (wdog_trip) begin
                        state   <= ST_TIMEOUT;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (runn_done) begin
                        state   <= ST_HALTED;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (state == ST_STEP_WAIT) begin
                        // One enabled cycle per step; a step during that cycle is dropped.
                        core_en <= !core_en && step;
                    end
                end
                ST_HALTED, ST_TIMEOUT: begin
                    core_en <= 1'b0;
                end
                default: begin
                    state    <= ST_RST_HOLD;
                    hold_cnt <= '0;
                    core_rst <= 1'b1;
                    core_en  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard testbench for cpu_run_ctrl (RST_CYCLES=4, WDOG_LIMIT=50); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_cpu_run_ctrl;

    localparam int CNT_W      = 32;
    localparam int RST_CYCLES = 4;
    localparam int WDOG_LIMIT = 50;
    localparam int PC_W       = 32;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [1:0]       mode;
    logic             start;
    logic             step;
    logic [CNT_W-1:0] run_count;
    logic             halt_in;
    logic [PC_W-1:0]  pc_in;
    logic             core_rst;
    logic             core_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic             busy;
    logic             done;
    logic             timeout;
`ifdef RUN_CTRL_BKPT_EN
    logic [PC_W-1:0]  bkpt_addr;
    logic             bkpt_valid;
    logic             bkpt_hit;
`endif

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    cpu_run_ctrl #(
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES),
        .WDOG_LIMIT (WDOG_LIMIT),
        .PC_W       (PC_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .mode       (mode),
        .start      (start),
        .step       (step),
        .run_count  (run_count),
        .halt_in    (halt_in),
        .pc_in      (pc_in),
`ifdef RUN_CTRL_BKPT_EN
        .bkpt_addr  (bkpt_addr),
        .bkpt_valid (bkpt_valid),
        .bkpt_hit   (bkpt_hit),
`endif
        .core_rst   (core_rst),
        .core_en    (core_en),
        .cycle_cnt  (cycle_cnt),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] observed);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("sb_underflow", 32'(expQ.size()), 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    // Holds RESET for 3 cycles and measures how long core_rst stays high afterwards.
    task automatic applyReset(output int rstLen);
        RESET     = 1'b1;
        start     = 1'b0;
        step      = 1'b0;
        halt_in   = 1'b0;
        mode      = 2'd0;
        run_count = '0;
        pc_in     = '0;
        repeat (3) @(negedge CLK);
        RESET  = 1'b0;
        rstLen = 0;
        while (core_rst && rstLen < 20) begin
            rstLen++;
            @(negedge CLK);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [CNT_W-1:0] n);
        mode      = m;
        run_count = n;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic countEnables(input int cycles, output int en);
        en = 0;
        for (int i = 0; i < cycles; i++) begin
            if (core_en) en++;
            @(negedge CLK);
        end
    endtask

    // Raises halt_in during the n-th enabled cycle; returns at the next falling edge.
    task automatic runUntilHalt(input int n, output int reached);
        int en = 0;
        reached = 0;
        for (int i = 0; i < 120; i++) begin
            if (core_en) begin
                en++;
                if (en == n) begin
                    halt_in = 1'b1;
                    @(negedge CLK);
                    halt_in = 1'b0;
                    reached = 1;
                    break;
                end
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        int rstLen;
        int en;
        int run;
        int maxRun;
        int reached;

`ifdef RUN_CTRL_BKPT_EN
        bkpt_addr  = 32'h0000_0010;
        bkpt_valid = 1'b0;
`endif

        // Reset stretching and idle outputs
        pushExpect("rst_len", 4);
        pushExpect("idle_core_en", 0);
        pushExpect("idle_busy", 0);
        pushExpect("idle_done", 0);
        pushExpect("idle_timeout", 0);
        pushExpect("idle_cycle_cnt", 0);
        applyReset(rstLen);
        popCheck(32'(rstLen));
        popCheck(32'(core_en));
        popCheck(32'(busy));
        popCheck(32'(done));
        popCheck(32'(timeout));
        popCheck(cycle_cnt);

        // Run-N with N=10
        pushExpect("runn_en_total", 10);
        pushExpect("runn_en_consecutive", 10);
        pushExpect("runn_cycle_cnt", 10);
        pushExpect("runn_done", 1);
        pushExpect("runn_busy", 0);
        applyStimulus(2'd2, 10);
        en = 0; run = 0; maxRun = 0;
        for (int i = 0; i < 20; i++) begin
            if (core_en) begin
                en++;
                run++;
                if (run > maxRun) maxRun = run;
            end else begin
                run = 0;
            end
            @(negedge CLK);
        end
        popCheck(32'(en));
        popCheck(32'(maxRun));
        popCheck(cycle_cnt);
        popCheck(32'(done));
        popCheck(32'(busy));

        // Run-N with N=0 halts without executing
        applyReset(rstLen);
        pushExpect("runn0_en", 0);
        pushExpect("runn0_done", 1);
        pushExpect("runn0_cycle_cnt", 0);
        applyStimulus(2'd2, 0);
        countEnables(5, en);
        popCheck(32'(en));
        popCheck(32'(done));
        popCheck(cycle_cnt);

        // Single-step: three pulses, the second held into its enable cycle
        applyReset(rstLen);
        pushExpect("step_en_total", 3);
        pushExpect("step_cycle_cnt", 3);
        pushExpect("step_busy", 1);
        applyStimulus(2'd1, 0);
        en = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            @(negedge CLK);
            if (core_en) en++;
            step = (p == 1);
            @(negedge CLK);
            if (core_en) en++;
            step = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                if (core_en) en++;
            end
        end
        popCheck(32'(en));
        popCheck(cycle_cnt);
        popCheck(32'(busy));

        // Free-run halted on enabled cycle 7; later start is ignored
        applyReset(rstLen);
        pushExpect("halt7_reached", 1);
        pushExpect("halt7_core_en", 0);
        pushExpect("halt7_done", 1);
        pushExpect("halt7_cycle_cnt", 7);
        pushExpect("halt7_timeout", 0);
        pushExpect("halt7_restart_en", 0);
        pushExpect("halt7_restart_cnt", 7);
        pushExpect("halt7_restart_done", 1);
        applyStimulus(2'd0, 0);
        runUntilHalt(7, reached);
        popCheck(32'(reached));
        popCheck(32'(core_en));
        popCheck(32'(done));
        popCheck(cycle_cnt);
        popCheck(32'(timeout));
        applyStimulus(2'd0, 0);
        countEnables(5, en);
        popCheck(32'(en));
        popCheck(cycle_cnt);
        popCheck(32'(done));

        // Watchdog trips after 50 enabled cycles
        applyReset(rstLen);
        pushExpect("wdog_en_total", 50);
        pushExpect("wdog_timeout", 1);
        pushExpect("wdog_done", 0);
        pushExpect("wdog_cycle_cnt", 50);
        pushExpect("wdog_core_en", 0);
        applyStimulus(2'd0, 0);
        en = 0;
        for (int i = 0; i < 100 && !(timeout || done); i++) begin
            if (core_en) en++;
            @(negedge CLK);
        end
        popCheck(32'(en));
        popCheck(32'(timeout));
        popCheck(32'(done));
        popCheck(cycle_cnt);
        popCheck(32'(core_en));

        // Halt on the watchdog cycle wins
        applyReset(rstLen);
        pushExpect("wdhalt_reached", 1);
        pushExpect("wdhalt_done", 1);
        pushExpect("wdhalt_timeout", 0);
        pushExpect("wdhalt_cycle_cnt", 50);
        applyStimulus(2'd0, 0);
        runUntilHalt(50, reached);
        popCheck(32'(reached));
        popCheck(32'(done));
        popCheck(32'(timeout));
        popCheck(cycle_cnt);

        // Reserved mode runs free; start while busy is ignored
        applyReset(rstLen);
        pushExpect("mode3_core_en", 1);
        pushExpect("mode3_busy", 1);
        pushExpect("mode3_done", 0);
        pushExpect("busy_start_core_en", 1);
        applyStimulus(2'd3, 0);
        repeat (3) @(negedge CLK);
        popCheck(32'(core_en));
        popCheck(32'(busy));
        popCheck(32'(done));
        applyStimulus(2'd1, 0);
        @(negedge CLK);
        popCheck(32'(core_en));

        // RESET mid-run at cycle_cnt=20
        applyReset(rstLen);
        pushExpect("midrst_reached", 1);
        pushExpect("midrst_core_en", 0);
        pushExpect("midrst_core_rst", 1);
        pushExpect("midrst_cycle_cnt", 0);
        pushExpect("midrst_busy", 0);
        pushExpect("midrst_rst_len", 4);
        applyStimulus(2'd0, 0);
        reached = 0;
        for (int i = 0; i < 60; i++) begin
            if (cycle_cnt == 20) begin
                reached = 1;
                break;
            end
            @(negedge CLK);
        end
        popCheck(32'(reached));
        RESET = 1'b1;
        @(negedge CLK);
        popCheck(32'(core_en));
        popCheck(32'(core_rst));
        popCheck(cycle_cnt);
        popCheck(32'(busy));
        RESET  = 1'b0;
        rstLen = 0;
        while (core_rst && rstLen < 20) begin
            rstLen++;
            @(negedge CLK);
        end
        popCheck(32'(rstLen));

`ifdef RUN_CTRL_BKPT_EN
        // Breakpoint on the 5th enabled cycle returns to IDLE, start resumes
        applyReset(rstLen);
        bkpt_valid = 1'b1;
        pushExpect("bkpt_reached", 1);
        pushExpect("bkpt_hit", 1);
        pushExpect("bkpt_busy", 0);
        pushExpect("bkpt_core_en", 0);
        pushExpect("bkpt_cycle_cnt", 5);
        pushExpect("bkpt_resume_hit", 0);
        pushExpect("bkpt_resume_cnt", 8);
        applyStimulus(2'd0, 0);
        en = 0;
        reached = 0;
        for (int i = 0; i < 40; i++) begin
            if (core_en) begin
                en++;
                if (en == 5) begin
                    pc_in = 32'h0000_0010;
                    @(negedge CLK);
                    pc_in = '0;
                    reached = 1;
                    break;
                end
            end
            @(negedge CLK);
        end
        popCheck(32'(reached));
        popCheck(32'(bkpt_hit));
        popCheck(32'(busy));
        popCheck(32'(core_en));
        popCheck(cycle_cnt);
        applyStimulus(2'd2, 3);
        repeat (4) @(negedge CLK);
        popCheck(32'(bkpt_hit));
        popCheck(cycle_cnt);
        bkpt_valid = 1'b0;
`endif

        checkOutput("sb_leftover", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
